// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - shared types and default widths for the BTB update controller
package btb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } btb_state_e;

    localparam int BTB_ADDR_WIDTH  = 64;
    localparam int BTB_INDEX_WIDTH = 2;
    localparam int BTB_BIA_WIDTH   = 60;
    localparam int BTB_WAY_WIDTH   = 2;
    localparam int BTB_FIFO_DEPTH  = 4;

endpackage

// File: rtl/btb_upd_fifo.sv
// rtl/btb_upd_fifo.sv - update queue with occupancy count; push is refused when full
module btb_upd_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                       clk_i,
    input  logic                       arstn_i,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [DATA_WIDTH-1:0]      wdata_i,
    input  logic                       pop_i,
    output logic [DATA_WIDTH-1:0]      rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  push_ok;
    logic                  pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/btb_update_ctrl.sv
// rtl/btb_update_ctrl.sv - queues resolved taken-branch updates into the BTB write port
// Set-invalidation walk is built only when BTB_FLUSH_EN is defined.
module btb_update_ctrl
    import btb_pkg::*;
#(
    parameter int ADDR_WIDTH  = BTB_ADDR_WIDTH,
    parameter int INDEX_WIDTH = BTB_INDEX_WIDTH,
    parameter int BIA_WIDTH   = BTB_BIA_WIDTH,
    parameter int WAY_WIDTH   = BTB_WAY_WIDTH,
    parameter int FIFO_DEPTH  = BTB_FIFO_DEPTH
) (
    input  logic                          clk_i,
    input  logic                          arstn_i,
    input  logic                          upd_valid_i,
    output logic                          upd_ready_o,
    input  logic [ADDR_WIDTH-1:0]         upd_pc_i,
    input  logic [ADDR_WIDTH-1:0]         upd_target_i,
    input  logic [WAY_WIDTH-1:0]          upd_way_i,
    input  logic                          stall_fetch_i,
    output logic                          btb_wr_en_o,
    output logic [INDEX_WIDTH-1:0]        btb_wr_index_o,
    output logic [BIA_WIDTH-1:0]          btb_wr_bia_o,
    output logic [WAY_WIDTH-1:0]          btb_wr_way_o,
    output logic [ADDR_WIDTH-1:0]         btb_wr_target_o,
    input  logic                          flush_req_i,
    output logic                          flush_busy_o,
    output logic                          flush_done_o,
    output logic                          btb_inv_o,
    output logic [INDEX_WIDTH-1:0]        btb_inv_index_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);

    typedef struct packed {
        logic [INDEX_WIDTH-1:0] index;
        logic [BIA_WIDTH-1:0]   bia;
        logic [WAY_WIDTH-1:0]   way;
        logic [ADDR_WIDTH-1:0]  target;
    } upd_entry_t;

    upd_entry_t push_entry;
    upd_entry_t head_entry;
    logic       full;
    logic       empty;
    logic       push;
    logic       in_idle;
    logic       flush_start;
    logic [1:0] unused_pc_lsb;

    assign unused_pc_lsb     = upd_pc_i[1:0];
    assign push_entry.index  = upd_pc_i[INDEX_WIDTH+1:2];
    assign push_entry.bia    = upd_pc_i[ADDR_WIDTH-1:INDEX_WIDTH+2];
    assign push_entry.way    = upd_way_i;
    assign push_entry.target = upd_target_i;

`ifdef BTB_FLUSH_EN
    localparam logic [INDEX_WIDTH-1:0] INV_LAST = {INDEX_WIDTH{1'b1}};

    btb_state_e             state_q;
    logic [INDEX_WIDTH-1:0] inv_idx_q;

    assign in_idle         = (state_q == ST_IDLE);
    assign flush_start     = flush_req_i & in_idle;
    assign flush_busy_o    = (state_q == ST_FLUSH);
    assign btb_inv_o       = flush_busy_o;
    assign btb_inv_index_o = inv_idx_q;
    assign flush_done_o    = flush_busy_o & (inv_idx_q == INV_LAST);

    // One set is invalidated per cycle; the write port is ours for the whole walk.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q   <= ST_IDLE;
            inv_idx_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    inv_idx_q <= '0;
                    if (flush_req_i) begin
                        state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (inv_idx_q == INV_LAST) begin
                        state_q   <= ST_IDLE;
                        inv_idx_q <= '0;
                    end else begin
                        inv_idx_q <= inv_idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    inv_idx_q <= '0;
                end
            endcase
        end
    end
`else
    logic unused_flush_req;

    assign unused_flush_req = flush_req_i;
    assign in_idle          = 1'b1;
    assign flush_start      = 1'b0;
    assign flush_busy_o     = 1'b0;
    assign btb_inv_o        = 1'b0;
    assign btb_inv_index_o  = '0;
    assign flush_done_o     = 1'b0;
`endif

    assign upd_ready_o = ~full & in_idle;
    assign push        = upd_valid_i & upd_ready_o & ~flush_start;
    // A flush request wins over a head entry that would otherwise write this cycle.
    assign btb_wr_en_o = ~empty & ~stall_fetch_i & in_idle & ~flush_start;

    assign btb_wr_index_o  = head_entry.index;
    assign btb_wr_bia_o    = head_entry.bia;
    assign btb_wr_way_o    = head_entry.way;
    assign btb_wr_target_o = head_entry.target;

    btb_upd_fifo #(
        .DATA_WIDTH ($bits(upd_entry_t)),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .clear_i (flush_start),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (btb_wr_en_o),
        .rdata_o (head_entry),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count_o)
    );

endmodule
